// File: rtl/bus_arb2_if.sv
// Two-master to one-slave bus bundle: master requests and write payloads in, grants and muxed slave bus out.
// Latency: none, this is wiring only.
// Backpressure: a master holds its request and payload until it sees its grant.
interface bus_arb2_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_wr;
  logic        m1_wr;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [63:0] m0_dout;
  logic [63:0] m1_dout;
  logic        m0_grant;
  logic        m1_grant;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic        owner;

  // Requester side: drives requests and payloads, observes grants and the slave bus.
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    input  m0_grant, m1_grant, s_wr, s_addr, s_din, owner
  );

  // Arbiter side: consumes requests and payloads, produces grants and the slave bus.
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    output m0_grant, m1_grant, s_wr, s_addr, s_din, owner
  );
endinterface

// File: rtl/bus_arb2.sv
// Two-master bus arbiter: round-robin on contention, bounded hold, combinational slave-side mux.
// Latency: grant registered, one edge after the request is sampled; mux path is zero-cycle.
// Backpressure: a master without a grant waits with its request high; its write never reaches the slave.
module bus_arb2 #(
  parameter int MAX_HOLD = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  bus_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Last hold count value; reaching it under contention hands the bus over.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       owner_q;
  logic       owner_nxt;

  // State, hold counter and last-owner registers; reset leaves owner=1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      owner_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      owner_q  <= owner_nxt;
    end
  end

  // Next-state selection: a dropped request yields first, then the hold limit forces a handover.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_nxt = owner_q ? GRANT0 : GRANT1;
        end else if (bus.m0_req) begin
          state_nxt = GRANT0;
        end else if (bus.m1_req) begin
          state_nxt = GRANT1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT0: begin
        if (!bus.m0_req) begin
          state_nxt = bus.m1_req ? GRANT1 : IDLE;
        end else if (bus.m1_req && (hold_cnt == HOLD_LAST)) begin
          state_nxt = GRANT1;
        end else begin
          state_nxt = GRANT0;
        end
      end
      GRANT1: begin
        if (!bus.m1_req) begin
          state_nxt = bus.m0_req ? GRANT0 : IDLE;
        end else if (bus.m0_req && (hold_cnt == HOLD_LAST)) begin
          state_nxt = GRANT0;
        end else begin
          state_nxt = GRANT1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold counter clears on every state change and saturates at the hold limit while the grant stays put.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if ((state_nxt != state) || (state_nxt == IDLE)) begin
      hold_cnt_nxt = 8'd0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end
  end

  // Owner tracks the most recent grant target and is left untouched while idle.
  always_comb begin
    owner_nxt = owner_q;
    if (state_nxt == GRANT0) begin
      owner_nxt = 1'b0;
    end else if (state_nxt == GRANT1) begin
      owner_nxt = 1'b1;
    end
  end

  // Grants decode the state register only, so async reset removes them immediately.
  always_comb begin
    bus.m0_grant = (state == GRANT0);
    bus.m1_grant = (state == GRANT1);
    bus.owner    = owner_q;
  end

  // Slave-side mux: only the granted master reaches the slave; idle drives an all-zero bus.
  always_comb begin
    bus.s_wr   = 1'b0;
    bus.s_addr = 16'h0000;
    bus.s_din  = 64'h0;
    unique case (state)
      GRANT0: begin
        bus.s_wr   = bus.m0_wr;
        bus.s_addr = bus.m0_addr;
        bus.s_din  = bus.m0_dout;
      end
      GRANT1: begin
        bus.s_wr   = bus.m1_wr;
        bus.s_addr = bus.m1_addr;
        bus.s_din  = bus.m1_dout;
      end
      default: begin
        bus.s_wr   = 1'b0;
        bus.s_addr = 16'h0000;
        bus.s_din  = 64'h0;
      end
    endcase
  end

  // Both grants together would short two masters onto the slave.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.m0_grant && bus.m1_grant));

  // A slave write must come from whichever master holds the grant.
  a_wr_granted: assert property (@(posedge clk) disable iff (!reset_n)
    bus.s_wr |-> (bus.m0_grant || bus.m1_grant));

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: directed request patterns, per-cycle comparison against a grant-holder model.
// Latency: model updates on the same edge as the DUT; outputs compared on the falling edge.
// Backpressure: not applicable; requests are held or dropped directly by the stimulus.
module tb_bus_arb2;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  bit   chk_en;

  bus_arb2_if bus ();

  bus_arb2 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who holds the bus (-1 none), how many cycles it has held it, and the last grant target.
  int m_who  = -1;
  int m_run  = 0;
  int m_last = 1;
  int m_nxt;
  bit m_r0;
  bit m_r1;

  function automatic bit req_of(int who, bit r0, bit r1);
    return (who == 0) ? r0 : r1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_who  = -1;
      m_run  = 0;
      m_last = 1;
    end else begin
      m_r0 = bus.m0_req;
      m_r1 = bus.m1_req;
      if (m_who < 0) begin
        if (m_r0 && m_r1) m_nxt = (m_last == 1) ? 0 : 1;
        else if (m_r0)    m_nxt = 0;
        else if (m_r1)    m_nxt = 1;
        else              m_nxt = -1;
      end else if (!req_of(m_who, m_r0, m_r1)) begin
        m_nxt = req_of(1 - m_who, m_r0, m_r1) ? (1 - m_who) : -1;
      end else if (req_of(1 - m_who, m_r0, m_r1) && (m_run >= MAX_HOLD)) begin
        m_nxt = 1 - m_who;
      end else begin
        m_nxt = m_who;
      end
      if (m_nxt != m_who) m_run = (m_nxt < 0) ? 0 : 1;
      else if (m_nxt >= 0) m_run = m_run + 1;
      if (m_nxt >= 0) m_last = m_nxt;
      m_who = m_nxt;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_hold();
    if (m_who < 0) return 0;
    return (m_run - 1 < MAX_HOLD - 1) ? (m_run - 1) : (MAX_HOLD - 1);
  endfunction

  // Per-cycle comparison of every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_grant", 64'(bus.m0_grant), 64'(m_who == 0));
      check("m1_grant", 64'(bus.m1_grant), 64'(m_who == 1));
      check("owner",    64'(bus.owner),    64'(m_last));
      check("hold_cnt", 64'(dut.hold_cnt), 64'(exp_hold()));
      check("s_wr",   64'(bus.s_wr),
            (m_who == 0) ? 64'(bus.m0_wr) : (m_who == 1) ? 64'(bus.m1_wr) : 64'h0);
      check("s_addr", 64'(bus.s_addr),
            (m_who == 0) ? 64'(bus.m0_addr) : (m_who == 1) ? 64'(bus.m1_addr) : 64'h0);
      check("s_din",  bus.s_din,
            (m_who == 0) ? bus.m0_dout : (m_who == 1) ? bus.m1_dout : 64'h0);
      check("grant_excl", 64'(bus.m0_grant & bus.m1_grant), 64'h0);
    end
  end

  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input bit r0, input bit r1);
    bus.m0_req = r0;
    bus.m1_req = r1;
  endtask

  logic [1:0] req_tbl [12];

  initial begin
    errors  = 0;
    checks  = 0;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    set_req(1'b0, 1'b0);
    bus.m0_wr   = 1'b1;
    bus.m1_wr   = 1'b1;
    bus.m0_addr = 16'hA000;
    bus.m1_addr = 16'hB111;
    bus.m0_dout = 64'h0000_0000_AAAA_0000;
    bus.m1_dout = 64'h1111_0000_0000_BBBB;

    // Reset state.
    tick();
    chk_en = 1'b1;
    check("rst_m0_grant", 64'(bus.m0_grant), 64'h0);
    check("rst_m1_grant", 64'(bus.m1_grant), 64'h0);
    check("rst_owner",    64'(bus.owner),    64'h1);
    check("rst_s_wr",     64'(bus.s_wr),     64'h0);
    check("rst_s_addr",   64'(bus.s_addr),   64'h0);
    check("rst_s_din",    bus.s_din,         64'h0);
    tick();

    // Simultaneous first requests after reset go to M0.
    reset_n = 1'b1;
    set_req(1'b1, 1'b1);
    tick();
    check("first_m0_grant", 64'(bus.m0_grant), 64'h1);
    check("first_owner",    64'(bus.owner),    64'h0);
    check("first_s_addr",   64'(bus.s_addr),   64'hA000);

    // Continuous contention alternates every MAX_HOLD cycles.
    for (int i = 1; i < 16; i++) begin
      tick();
      check("alt_m0_grant", 64'(bus.m0_grant), 64'(((i / 4) % 2) == 0));
      check("alt_m1_grant", 64'(bus.m1_grant), 64'(((i / 4) % 2) == 1));
    end

    // Both drop -> idle, then M1 alone keeps its grant with a saturated counter.
    set_req(1'b0, 1'b0);
    tick();
    check("idle_m1_grant", 64'(bus.m1_grant), 64'h0);
    set_req(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("solo_m1_grant", 64'(bus.m1_grant), 64'h1);
      check("solo_hold", 64'(dut.hold_cnt), 64'((k - 1 < 3) ? (k - 1) : 3));
    end

    // Direct handover to M0, then M0 drops: idle bus ignores M1's write.
    set_req(1'b1, 1'b0);
    tick();
    check("hand_m0_grant", 64'(bus.m0_grant), 64'h1);
    set_req(1'b0, 1'b0);
    bus.m1_wr   = 1'b1;
    bus.m1_addr = 16'h0123;
    tick();
    check("drop_m0_grant", 64'(bus.m0_grant), 64'h0);
    check("drop_s_wr",     64'(bus.s_wr),     64'h0);
    check("drop_s_addr",   64'(bus.s_addr),   64'h0);
    check("drop_s_din",    bus.s_din,         64'h0);

    // GRANT1 at hold_cnt=2, M1 releases while M0 requests.
    set_req(1'b0, 1'b1);
    tick();
    tick();
    tick();
    check("g1_hold2", 64'(dut.hold_cnt), 64'h2);
    set_req(1'b1, 1'b0);
    tick();
    check("rel_m0_grant", 64'(bus.m0_grant), 64'h1);
    check("rel_hold",     64'(dut.hold_cnt), 64'h0);
    check("rel_s_din",    bus.s_din,         64'h0000_0000_AAAA_0000);

    // Holder drops on the very edge its hold limit would preempt it.
    set_req(1'b1, 1'b1);
    tick();
    tick();
    tick();
    check("pre_hold3", 64'(dut.hold_cnt), 64'h3);
    set_req(1'b0, 1'b1);
    tick();
    check("coinc_m1_grant", 64'(bus.m1_grant), 64'h1);
    check("coinc_hold",     64'(dut.hold_cnt), 64'h0);

    // Async reset between edges in GRANT1 drops grant and write at once.
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_m1_grant", 64'(bus.m1_grant), 64'h0);
    check("arst_s_wr",     64'(bus.s_wr),     64'h0);
    check("arst_owner",    64'(bus.owner),    64'h1);
    tick();
    tick();
    reset_n = 1'b1;
    set_req(1'b1, 1'b1);
    tick();
    check("post_rst_m0_grant", 64'(bus.m0_grant), 64'h1);
    check("post_rst_m1_grant", 64'(bus.m1_grant), 64'h0);

    // Mixed request sequence covered by the per-cycle model comparison.
    req_tbl = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b11,
                2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    bus.m0_wr = 1'b0;
    for (int j = 0; j < 12; j++) begin
      set_req(req_tbl[j][1], req_tbl[j][0]);
      bus.m1_addr = 16'(16'h0200 + j);
      tick();
    end
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
